data_sync_mc: RTL and testbench

- Multi-channel successor to the single-channel data synchroniser.
- Each of NUM_CH channels receives a data bus plus a level enable from a foreign domain. Each enable passes through a SYNC_STAGES-deep flop chain and a rising-edge detector. The edge pulse captures that channel's bus into a per-channel pending register.
- A round-robin arbiter drains pending words into a shared FIFO tagged with channel ID. The consumer reads the FIFO with a valid/ready handshake.

---
 rtl/data_sync_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 28 ++
 rtl/data_sync_mc.sv | 153 +++++++++++++++
 tb/tb_data_sync_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared constants and helpers for the multi-channel data synchroniser
package data_sync_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

    // Channel-ID width; a single channel still needs a one-bit tag.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop level synchroniser with rising-edge pulse
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], i_async};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign o_level = chain_q[SYNC_STAGES-1];
    assign o_rise  = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/data_sync_mc.sv
// rtl/data_sync_mc.sv - per-channel capture, round-robin drain into a tagged show-ahead FIFO
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int NUM_CH      = DEF_NUM_CH,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    localparam int CH_W        = ch_width(NUM_CH),
    localparam int AW          = $clog2(FIFO_DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_CH-1:0]            i_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic                         i_ready,
    input  logic                         i_clear_overrun,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]              o_ch,
    output logic [NUM_CH-1:0]            o_overrun,
    output logic [CW-1:0]                o_count
);

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [NUM_CH-1:0]     lvl;
    logic [NUM_CH-1:0]     pulse;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pdata_q [NUM_CH];
    logic [DATA_WIDTH-1:0] pdata_d [NUM_CH];
    logic [NUM_CH-1:0]     ovr_q, ovr_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic                  gnt_vld;
    logic [CH_W-1:0]       gnt_ch;

    entry_t                mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  fifo_valid, push, pop, push_ok;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_async (i_enable[c]),
            .o_level (lvl[c]),
            .o_rise  (pulse[c])
        );
    end

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid & i_ready;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    assign push_ok    = (count_q < CW'(FIFO_DEPTH)) | pop;
    assign push       = gnt_vld;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        if (push_ok) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(rr_q) + k) % NUM_CH;
                if (!gnt_vld && pend_q[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = idx[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
        end
    end

    always_comb begin
        logic granted;
        granted = 1'b0;
        pend_d  = pend_q;
        pdata_d = pdata_q;
        ovr_d   = i_clear_overrun ? '0 : ovr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            granted = gnt_vld && (gnt_ch == CH_W'(c));
            if (granted) begin
                pend_d[c] = 1'b0;
            end
            // New word is kept only if its slot is free or being drained this cycle.
            if (pulse[c] && lvl[c]) begin
                if (!pend_q[c] || granted) begin
                    pend_d[c]  = 1'b1;
                    pdata_d[c] = i_data[c*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    ovr_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_q   <= '0;
            ovr_q    <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pdata_q[c] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            ovr_q   <= ovr_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{ch: gnt_ch, data: pdata_q[gnt_ch]};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign o_valid   = fifo_valid;
    assign o_data    = mem_q[rd_ptr_q].data;
    assign o_ch      = mem_q[rd_ptr_q].ch;
    assign o_overrun = ovr_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// tb/tb_data_sync_mc.sv - scoreboard bench for data_sync_mc at default parameters
module tb_data_sync_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [1:0]  en;
    logic [15:0] din;
    logic        ov;
    logic [7:0]  od;
    logic [0:0]  och;
    logic [1:0]  oovr;
    logic [2:0]  ocnt;

    int total = 0;
    int bad   = 0;
    int sb[$];
    int n;

    data_sync_mc dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_data          (din),
        .i_ready         (rdy),
        .i_clear_overrun (clr),
        .o_valid         (ov),
        .o_data          (od),
        .o_ch            (och),
        .o_overrun       (oovr),
        .o_count         (ocnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int c, input logic [7:0] d);
        din[c*8 +: 8] = d;
        en[c] = 1'b1;
        repeat (4) tick();
        en[c] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!ov && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic drain;
        rdy = 1'b1;
        for (int i = 0; i < 40 && ocnt != 3'd0; i++) tick();
        check("drain_cnt", ocnt, 0);
        check("sb_left", sb.size(), 0);
    endtask

    // Scoreboard consumer: every accepted head word must match the oldest expected entry.
    always @(negedge clk) begin
        int e;
        if (!rst && ov && rdy) begin
            if (sb.size() == 0) begin
                check("sb_unexp", {23'd0, och, od}, 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("sb_ch", och, e / 256);
                check("sb_data", od, e % 256);
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b0; clr = 1'b0; en = 2'b00; din = 16'h0;
        tick();
        check("rst_valid", ov, 0);
        check("rst_count", ocnt, 0);
        check("rst_ovr", oovr, 0);
        check("rst_data", od, 0);
        check("rst_ch", och, 0);
        rst = 1'b0;

        // single word latency
        rdy = 1'b1;
        sb.push_back(8'hA5);
        din[7:0] = 8'hA5;
        en[0] = 1'b1;
        wait_valid(n);
        check("t1_lat", n, 4);
        check("t1_cnt", ocnt, 1);
        tick();
        check("t1_pop", ocnt, 0);
        en[0] = 1'b0;
        repeat (3) tick();

        // simultaneous channels, then rotated priority
        pulse_reset();
        rdy = 1'b1;
        sb.push_back(8'h11);
        sb.push_back(256 + 8'h22);
        din = {8'h22, 8'h11};
        en = 2'b11;
        wait_valid(n);
        check("t2_lat", n, 4);
        check("t2_first", och, 0);
        tick();
        check("t2_next_v", ov, 1);
        check("t2_next_ch", och, 1);
        en = 2'b00;
        repeat (5) tick();
        sb.push_back(8'h33);
        send(0, 8'h33);
        sb.push_back(256 + 8'h55);
        sb.push_back(8'h44);
        din = {8'h55, 8'h44};
        en = 2'b11;
        wait_valid(n);
        check("t2_rot", och, 1);
        repeat (3) tick();
        en = 2'b00;
        repeat (4) tick();
        check("t2_sb", sb.size(), 0);

        // saturation with one word left pending
        pulse_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h10 + i);
            send(0, 8'(8'h10 + i));
        end
        check("t3_full", ocnt, 4);
        check("t3_valid", ov, 1);
        drain();

        // overrun on ch1 while the FIFO is full, then clear
        pulse_reset();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'h20 + i);
            send(0, 8'(8'h20 + i));
        end
        sb.push_back(256 + 8'h01);
        send(1, 8'h01);
        check("t4_no_ovr", oovr, 2'b00);
        send(1, 8'h02);
        check("t4_ovr", oovr, 2'b10);
        send(1, 8'h03);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr", oovr, 2'b00);
        drain();

        // reset with a partly full FIFO, ch0 pending and enable still high
        pulse_reset();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'h40 + i);
            send(0, 8'(8'h40 + i));
        end
        din[7:0] = 8'h77;
        en[0] = 1'b1;
        repeat (3) tick();
        check("t5_pre_cnt", ocnt, 3);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", ov, 0);
        check("t5_rst_cnt", ocnt, 0);
        check("t5_rst_data", od, 0);
        check("t5_rst_ovr", oovr, 0);
        sb.delete();
        sb.push_back(8'h77);
        rst = 1'b0;
        rdy = 1'b1;
        wait_valid(n);
        check("t5_lat", n, 4);
        repeat (6) tick();
        check("t5_once", ocnt, 0);
        en[0] = 1'b0;
        repeat (3) tick();
        check("t5_sb", sb.size(), 0);

        // full FIFO: pop and push in the same cycle
        pulse_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h60 + i);
            send(0, 8'(8'h60 + i));
        end
        check("t6_full", ocnt, 4);
        rdy = 1'b1;
        tick();
        check("t6_same", ocnt, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
